// File: rtl/sms_card_trigger_ss_if.sv
`default_nettype none
// =============================================================================
// Module   : sms_card_trigger_ss_if
// Purpose  : Pin bundle of the SMS trigger / single-shot card.
// Revision : 1.0 - initial release
// =============================================================================
interface sms_card_trigger_ss_if;
  logic a;
  logic b;
  logic d;
  logic e;
  logic f;
  logic g;
  logic k;
  logic c;
  logic h;
  logic p;
  logic q;

  modport master (output a, b, d, e, f, g, k, input c, h, p, q);
  modport slave  (input a, b, d, e, f, g, k, output c, h, p, q);
endinterface
`default_nettype wire

// File: rtl/sms_card_trigger_ss.sv
`default_nettype none
// =============================================================================
// Module   : sms_card_trigger_ss
// Purpose  : Binary trigger (DC/AC set-reset, complement) plus locked single shot.
// Revision : 1.0 - initial release
// =============================================================================
module sms_card_trigger_ss #(
  parameter int PULSE_CYCLES    = 4,
  parameter int RECOVERY_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  sms_card_trigger_ss_if.slave pins
);

  localparam int MAX_CYCLES = (PULSE_CYCLES > RECOVERY_CYCLES) ?
                              ((PULSE_CYCLES > 2) ? PULSE_CYCLES : 2) :
                              ((RECOVERY_CYCLES > 2) ? RECOVERY_CYCLES : 2);
  localparam int CNT_W = $clog2(MAX_CYCLES);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REC_LOAD   = CNT_W'((RECOVERY_CYCLES > 0) ? RECOVERY_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    SS_IDLE    = 2'd0,
    SS_PULSE   = 2'd1,
    SS_RECOVER = 2'd2
  } ss_state_t;

  // Open-collector drivers float when off; the card pull-up turns z into 1.
  function automatic logic pull_up(input logic pin);
    if (pin === 1'b0)      return 1'b0;
    else if (pin === 1'b1) return 1'b1;
    else if (pin === 1'bz) return 1'b1;
    else                   return 1'b0;
  endfunction

  logic a_rd, b_rd, d_rd, e_rd, f_rd, g_rd, k_rd;
  logic e_fall, g_fall, k_fall;
  logic state_d, state_q;
  logic e_prev_d, e_prev_q, g_prev_d, g_prev_q, k_prev_d, k_prev_q;
  ss_state_t ss_d, ss_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic p_d, p_q;
  logic to_idle;

  always_comb begin
    a_rd = pull_up(pins.a);
    b_rd = pull_up(pins.b);
    d_rd = pull_up(pins.d);
    e_rd = pull_up(pins.e);
    f_rd = pull_up(pins.f);
    g_rd = pull_up(pins.g);
    k_rd = pull_up(pins.k);
  end

  assign e_fall = ~e_rd & e_prev_q;
  assign g_fall = ~g_rd & g_prev_q;
  assign k_fall = ~k_rd & k_prev_q;

  // Edges are tracked every cycle, so an edge arriving on a closed gate is lost.
  always_comb begin
    e_prev_d = e_rd;
    g_prev_d = g_rd;
    k_prev_d = k_rd;
    state_d  = state_q;
    if (!b_rd)                                   state_d = 1'b0;
    else if (!a_rd)                              state_d = 1'b1;
    else if (e_fall && d_rd && g_fall && f_rd)   state_d = ~state_q;
    else if (e_fall && d_rd)                     state_d = 1'b1;
    else if (g_fall && f_rd)                     state_d = 1'b0;
  end

  // Leaving PULSE/RECOVER lands in IDLE on the same edge, so a k edge there is taken.
  always_comb begin
    ss_d    = ss_q;
    cnt_d   = cnt_q;
    to_idle = 1'b0;
    case (ss_q)
      SS_IDLE: to_idle = 1'b1;
      SS_PULSE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (RECOVERY_CYCLES == 0) begin
          to_idle = 1'b1;
        end else begin
          ss_d  = SS_RECOVER;
          cnt_d = REC_LOAD;
        end
      end
      SS_RECOVER: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             to_idle = 1'b1;
      end
      default: to_idle = 1'b1;
    endcase
    if (to_idle) begin
      if (k_fall) begin
        ss_d  = SS_PULSE;
        cnt_d = PULSE_LOAD;
      end else begin
        ss_d  = SS_IDLE;
        cnt_d = '0;
      end
    end
    p_d = (ss_d == SS_PULSE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= 1'b0;
      e_prev_q <= 1'b1;
      g_prev_q <= 1'b1;
      k_prev_q <= 1'b1;
      ss_q     <= SS_IDLE;
      cnt_q    <= '0;
      p_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      e_prev_q <= e_prev_d;
      g_prev_q <= g_prev_d;
      k_prev_q <= k_prev_d;
      ss_q     <= ss_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
    end
  end

  assign pins.c = state_q;
  assign pins.h = ~state_q;
  assign pins.p = p_q;
  assign pins.q = ~p_q;

endmodule
`default_nettype wire
